// File: rtl/ring_arb_pkg.sv
// Shared types and helpers for the ring round-robin arbiter.
// Helpers operate on 32-bit vectors, so requester count is limited to 32.
package ring_arb_pkg;

    localparam int MAX_REQ = 32;

    typedef enum logic {
        IDLE = 1'b0,
        BUSY = 1'b1
    } state_t;

    function automatic int onehot2bin(input logic [MAX_REQ-1:0] v);
        logic [MAX_REQ-1:0] tmp;
        int                 idx;
        tmp = v;
        idx = 0;
        for (int i = 0; i < MAX_REQ; i++) begin
            if (tmp[0]) idx = idx | i;
            tmp = tmp >> 1;
        end
        return idx;
    endfunction

    // Rotate a one-hot vector of n live bits left by one, wrapping bit n-1 to bit 0.
    function automatic logic [MAX_REQ-1:0] rotl1(input logic [MAX_REQ-1:0] v, input int n);
        logic [MAX_REQ-1:0] mask;
        mask = ~({MAX_REQ{1'b1}} << n);
        return ((v << 1) | (v >> (n - 1))) & mask;
    endfunction

endpackage

// File: rtl/ring_rr_arbiter_if.sv
// Request/grant bundle between requesters (master) and the arbiter (slave).
interface ring_rr_arbiter_if #(
    parameter int NUMBER_OF_REQ = 4
);
    localparam int IW = $clog2(NUMBER_OF_REQ);

    logic [NUMBER_OF_REQ-1:0] req;
    logic [NUMBER_OF_REQ-1:0] gnt;
    logic                     gnt_valid;
    logic [IW-1:0]            gnt_id;
    logic                     preempt;

    modport master (
        output req,
        input  gnt,
        input  gnt_valid,
        input  gnt_id,
        input  preempt
    );

    modport slave (
        input  req,
        output gnt,
        output gnt_valid,
        output gnt_id,
        output preempt
    );

endinterface

// File: rtl/ring_arb_pick.sv
// Combinational priority pick: first request at or above the one-hot pointer,
// otherwise wrap around to the lowest request.
module ring_arb_pick #(
    parameter int NUMBER_OF_REQ = 4
) (
    input  logic [NUMBER_OF_REQ-1:0] req_i,
    input  logic [NUMBER_OF_REQ-1:0] ptr_i,
    output logic [NUMBER_OF_REQ-1:0] win_o,
    output logic                     any_req_o
);
    localparam logic [NUMBER_OF_REQ-1:0] ONE = {{(NUMBER_OF_REQ-1){1'b0}}, 1'b1};

    logic [NUMBER_OF_REQ-1:0] mask_ge;
    logic [NUMBER_OF_REQ-1:0] masked;

    // ptr is one-hot, so ~(ptr-1) selects every slot from ptr upward.
    assign mask_ge   = ~(ptr_i - ONE);
    assign masked    = req_i & mask_ge;
    assign any_req_o = |req_i;

    always_comb begin
        win_o = '0;
        if (|masked) win_o = masked & (~masked + ONE);
        else         win_o = req_i & (~req_i + ONE);
    end

endmodule

// File: rtl/ring_rr_arbiter.sv
// Round-robin arbiter with rotating one-hot priority pointer and registered grant.
// Optional per-tenure burst limit enabled by defining RING_ARB_BURST_LIMIT_EN.
module ring_rr_arbiter
    import ring_arb_pkg::*;
#(
    parameter int NUMBER_OF_REQ = 4,
    parameter int MAX_BURST     = 8
) (
    input  logic             clk,
    input  logic             stop,
    ring_rr_arbiter_if.slave bus
);
    localparam int N  = NUMBER_OF_REQ;
    localparam int IW = $clog2(N);

    state_t        state_q;
    logic [N-1:0]  ptr_q;
    logic [N-1:0]  gnt_q;
    logic [IW-1:0] gnt_id_q;
    logic          gnt_valid_q;

    logic [N-1:0]  win_d;
    logic [N-1:0]  ptr_d;
    logic [IW-1:0] gnt_id_d;
    logic          any_req;
    logic          owner_req;

    ring_arb_pick #(.NUMBER_OF_REQ(N)) u_pick (
        .req_i     (bus.req),
        .ptr_i     (ptr_q),
        .win_o     (win_d),
        .any_req_o (any_req)
    );

    assign ptr_d     = N'(rotl1(32'(win_d), N));
    assign gnt_id_d  = IW'(onehot2bin(32'(win_d)));
    assign owner_req = |(bus.req & gnt_q);

`ifdef RING_ARB_BURST_LIMIT_EN
    localparam int            CW       = $clog2(MAX_BURST);
    localparam logic [CW-1:0] CNT_LAST = CW'(MAX_BURST - 1);

    logic [CW-1:0] cnt_q;
    logic          preempt_q;
    logic          other_req;

    assign other_req   = |(bus.req & ~gnt_q);
    assign bus.preempt = preempt_q;
`else
    logic unused_burst;
    assign unused_burst = (MAX_BURST > 1);
    assign bus.preempt  = 1'b0;
`endif

    always_ff @(posedge clk or negedge stop) begin
        if (!stop) begin
            state_q     <= IDLE;
            ptr_q       <= {{(N-1){1'b0}}, 1'b1};
            gnt_q       <= '0;
            gnt_id_q    <= '0;
            gnt_valid_q <= 1'b0;
`ifdef RING_ARB_BURST_LIMIT_EN
            cnt_q       <= '0;
            preempt_q   <= 1'b0;
`endif
        end else begin
`ifdef RING_ARB_BURST_LIMIT_EN
            preempt_q <= 1'b0;
`endif
            unique case (state_q)
                IDLE: begin
                    if (any_req) begin
                        state_q     <= BUSY;
                        gnt_q       <= win_d;
                        gnt_id_q    <= gnt_id_d;
                        gnt_valid_q <= 1'b1;
                        ptr_q       <= ptr_d;
`ifdef RING_ARB_BURST_LIMIT_EN
                        cnt_q       <= '0;
`endif
                    end
                end
                BUSY: begin
                    // Owner release takes precedence over any burst-limit decision.
                    if (!owner_req) begin
                        state_q     <= IDLE;
                        gnt_q       <= '0;
                        gnt_id_q    <= '0;
                        gnt_valid_q <= 1'b0;
                    end
`ifdef RING_ARB_BURST_LIMIT_EN
                    else if (cnt_q == CNT_LAST) begin
                        // Saturate and keep the grant unless someone else is waiting.
                        if (other_req) begin
                            state_q     <= IDLE;
                            gnt_q       <= '0;
                            gnt_id_q    <= '0;
                            gnt_valid_q <= 1'b0;
                            preempt_q   <= 1'b1;
                        end
                    end else begin
                        cnt_q <= cnt_q + 1'b1;
                    end
`endif
                end
                default: state_q <= IDLE;
            endcase
        end
    end

    assign bus.gnt       = gnt_q;
    assign bus.gnt_id    = gnt_id_q;
    assign bus.gnt_valid = gnt_valid_q;

endmodule

// File: tb/tb_ring_rr_arbiter.sv
// Self-checking bench for ring_rr_arbiter: cycle model feeds an expectation queue.
module tb_ring_rr_arbiter;
    localparam int N  = 4;
    localparam int MB = 4;

    typedef struct packed {
        logic [3:0] gnt;
        logic [1:0] id;
        logic       vld;
        logic       pre;
    } exp_t;

    logic clk  = 1'b0;
    logic stop = 1'b1;
    always #5 clk = ~clk;

    ring_rr_arbiter_if #(.NUMBER_OF_REQ(N)) bus ();

    ring_rr_arbiter #(.NUMBER_OF_REQ(N), .MAX_BURST(MB)) dut (
        .clk  (clk),
        .stop (stop),
        .bus  (bus)
    );

    exp_t exp_q[$];
    int   n_checks = 0;
    int   n_fail   = 0;

    bit   m_busy;
    bit   m_pre;
    int   m_ptr;
    int   m_owner;
    int   m_cnt;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_checks++;
        if (obs !== exp) begin
            n_fail++;
            $display("FAIL %s got=%0h expected=%0h at %0t", tag, obs, exp, $time);
        end
    endtask

    function automatic void model_reset();
        m_busy  = 1'b0;
        m_pre   = 1'b0;
        m_ptr   = 0;
        m_owner = 0;
        m_cnt   = 0;
        exp_q.delete();
    endfunction

    function automatic void model_step(input logic [3:0] r);
        m_pre = 1'b0;
        if (!m_busy) begin
            for (int off = 0; off < N; off++) begin
                int i;
                i = (m_ptr + off) % N;
                if (((r >> i) & 4'b1) != 4'b0) begin
                    m_owner = i;
                    m_busy  = 1'b1;
                    m_ptr   = (i + 1) % N;
                    m_cnt   = 0;
                    break;
                end
            end
        end else if (((r >> m_owner) & 4'b1) == 4'b0) begin
            m_busy = 1'b0;
        end
`ifdef RING_ARB_BURST_LIMIT_EN
        else if (m_cnt == MB - 1) begin
            if ((r & ~(4'b1 << m_owner)) != 4'b0) begin
                m_busy = 1'b0;
                m_pre  = 1'b1;
            end
        end else begin
            m_cnt++;
        end
`endif
    endfunction

    function automatic exp_t model_out();
        exp_t e;
        e.gnt = m_busy ? (4'b1 << m_owner) : 4'b0;
        e.id  = m_busy ? 2'(m_owner) : 2'b0;
        e.vld = m_busy;
        e.pre = m_pre;
        return e;
    endfunction

    // Drive one request vector for one clock and score the registered outputs.
    task automatic cycle(input logic [3:0] r, input string tag);
        exp_t e;
        @(negedge clk);
        bus.req = r;
        model_step(r);
        exp_q.push_back(model_out());
        @(posedge clk);
        #1;
        if (exp_q.size() == 0) begin
            chk({tag, "_queue"}, 32'd0, 32'd1);
        end else begin
            e = exp_q.pop_front();
            chk({tag, "_gnt"}, 32'(bus.gnt), 32'(e.gnt));
            chk({tag, "_id"},  32'(bus.gnt_id), 32'(e.id));
            chk({tag, "_vld"}, 32'(bus.gnt_valid), 32'(e.vld));
            chk({tag, "_pre"}, 32'(bus.preempt), 32'(e.pre));
        end
    endtask

    // Assert reset between clock edges and confirm the grant drops without a clock.
    task automatic async_reset(input string tag);
        #2;
        stop    = 1'b0;
        bus.req = 4'hF;
        #1;
        chk({tag, "_rst_gnt"}, 32'(bus.gnt), 32'd0);
        chk({tag, "_rst_vld"}, 32'(bus.gnt_valid), 32'd0);
        chk({tag, "_rst_id"},  32'(bus.gnt_id), 32'd0);
        chk({tag, "_rst_pre"}, 32'(bus.preempt), 32'd0);
        @(posedge clk);
        #1;
        chk({tag, "_rst_hold"}, 32'(bus.gnt), 32'd0);
        model_reset();
        @(negedge clk);
        bus.req = 4'h0;
        stop    = 1'b1;
    endtask

    initial begin
        #100000;
        $display("FAIL watchdog expired at %0t", $time);
        $fatal(1, "watchdog");
    end

    initial begin
        int   order[$];
        int   exp_order[5];
        int   held;
        bit   prev_v;
        logic [3:0] r;

        exp_order = '{0, 1, 2, 3, 0};
        bus.req   = 4'h0;
        model_reset();
        async_reset("init");

        // Two requesters, then owner drops and the other is served after one idle cycle.
        cycle(4'b0101, "t2a"); chk("t2a_const", 32'(bus.gnt), 32'b0001);
        cycle(4'b0101, "t2b");
        cycle(4'b0100, "t2c"); chk("t2c_const", 32'(bus.gnt), 32'b0000);
        cycle(4'b0100, "t2d"); chk("t2d_const", 32'(bus.gnt), 32'b0100);
        chk("t2d_id_const", 32'(bus.gnt_id), 32'd2);

        // Reset in the middle of owner 2's tenure.
        async_reset("t1");
        cycle(4'b1000, "t1a"); chk("t1a_const", 32'(bus.gnt), 32'b1000);

        // Full contention, each owner holds two cycles then re-requests.
        async_reset("t3");
        held   = 0;
        prev_v = 1'b0;
        for (int c = 0; c < 15; c++) begin
            r = 4'hF;
            if (m_busy && held >= 2) r = r & ~(4'b1 << m_owner);
            cycle(r, "t3");
            if (m_busy) held++;
            else        held = 0;
            if (bus.gnt_valid && !prev_v) order.push_back(int'(bus.gnt_id));
            prev_v = bus.gnt_valid;
        end
        chk("t3_ngrants", 32'(order.size() >= 5), 32'd1);
        for (int k = 0; k < 5; k++)
            if (k < order.size()) chk("t3_order", 32'(order[k]), 32'(exp_order[k]));

        // Pointer wraps from slot 3 back to slot 0; release beats a same-cycle request.
        async_reset("t4");
        cycle(4'b1000, "t4a"); chk("t4a_const", 32'(bus.gnt), 32'b1000);
        cycle(4'b0000, "t4b"); chk("t4b_const", 32'(bus.gnt), 32'b0000);
        cycle(4'b1001, "t4c"); chk("t4c_const", 32'(bus.gnt), 32'b0001);
        cycle(4'b0010, "t4d"); chk("t4d_const", 32'(bus.gnt), 32'b0000);
        cycle(4'b0010, "t4e"); chk("t4e_const", 32'(bus.gnt), 32'b0010);

        // Two requesters holding requests continuously.
        async_reset("t5");
`ifdef RING_ARB_BURST_LIMIT_EN
        for (int c = 1; c <= 20; c++) begin
            int p;
            cycle(4'b0011, "t5");
            p = (c - 1) % 5;
            if (p == 4) begin
                chk("t5_gap_gnt", 32'(bus.gnt), 32'd0);
                chk("t5_gap_pre", 32'(bus.preempt), 32'd1);
            end else begin
                chk("t5_gnt", 32'(bus.gnt), ((((c - 1) / 5) % 2) != 0) ? 32'b0010 : 32'b0001);
                chk("t5_pre", 32'(bus.preempt), 32'd0);
            end
        end
`else
        for (int c = 1; c <= 12; c++) begin
            cycle(4'b0011, "t5");
            chk("t5_gnt", 32'(bus.gnt), 32'b0001);
            chk("t5_pre", 32'(bus.preempt), 32'd0);
        end
`endif

        // Lone requester is never preempted.
        async_reset("t6");
        for (int c = 0; c < 10; c++) begin
            cycle(4'b0001, "t6");
            chk("t6_gnt", 32'(bus.gnt), 32'b0001);
            chk("t6_pre", 32'(bus.preempt), 32'd0);
        end

        // Random traffic, owner usually keeps its request.
        async_reset("rnd");
        for (int c = 0; c < 60; c++) begin
            r = 4'($urandom_range(0, 15));
            if (m_busy && $urandom_range(0, 3) != 0) r = r | (4'b1 << m_owner);
            cycle(r, "rnd");
        end

        $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
        $finish;
    end

endmodule
